// File: rtl/s641_n178_bist_ctrl_if.sv
// Pin bundle between the s641/n178 BIST controller and the test wrapper.
// The slave side is the controller; the master side drives run control and the cone response.
interface s641_n178_bist_ctrl_if;
  logic        start;
  logic        abort;
  logic [15:0] golden;
  logic        cut_resp;
  logic [21:0] pat_out;
  logic        cut_en;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] pat_cnt;

  modport slave (
    input  start, abort, golden, cut_resp,
    output pat_out, cut_en, busy, done, pass, signature, pat_cnt
  );

  modport master (
    output start, abort, golden, cut_resp,
    input  pat_out, cut_en, busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/s641_n178_bist_ctrl.sv
// BIST controller for the s641 n178 cone: an x^22+x^21+1 LFSR drives the cone inputs and
// a 16-bit MISR compacts the response, which is compared to a golden signature.
module s641_n178_bist_ctrl #(
  parameter int unsigned  PATTERNS = 256,
  parameter logic [21:0]  SEED     = 22'h000001
) (
  input  logic                   CK,
  input  logic                   RN,
  s641_n178_bist_ctrl_if.slave   bus
);

  // A zero seed would lock the LFSR, so it is replaced by the minimal non-zero state.
  localparam logic [21:0] SEED_EFF = (SEED == 22'd0) ? 22'h000001 : SEED;
  localparam logic [15:0] PAT_LAST = 16'(PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RUN, S_CMP, S_DONE
  } state_t;

  state_t      st, nxt;
  logic [21:0] lfsr;
  logic [15:0] misr;
  logic [15:0] cnt;
  logic        pass_q;

  logic [21:0] lfsr_nx;
  logic [15:0] misr_nx;
  logic [15:0] cnt_nx;
  logic        run_last;
  logic        act;

  assign lfsr_nx  = {lfsr[20:0], lfsr[21] ^ lfsr[20]};
  assign misr_nx  = {misr[14:0], misr[15] ^ misr[14] ^ misr[12] ^ misr[3] ^ bus.cut_resp};
  assign cnt_nx   = cnt + 16'd1;
  assign run_last = (cnt_nx == PAT_LAST);
  assign act      = (st == S_INIT) || (st == S_RUN) || (st == S_CMP);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) st <= S_IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:  if (bus.start) nxt = S_INIT;
      S_INIT:  nxt = bus.abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (bus.abort)     nxt = S_IDLE;
        else if (run_last) nxt = S_CMP;
      end
      S_CMP:   nxt = bus.abort ? S_IDLE : S_DONE;
      S_DONE:  if (bus.start) nxt = S_INIT;
      default: nxt = S_IDLE;
    endcase
  end

  // The RUN edge that sees abort still compacts its pattern; after that everything freezes.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      lfsr   <= SEED_EFF;
      misr   <= 16'h0000;
      cnt    <= 16'h0000;
      pass_q <= 1'b0;
    end else begin
      case (st)
        S_IDLE, S_DONE: begin
          if (bus.start) pass_q <= 1'b0;
        end
        S_INIT: begin
          if (!bus.abort) begin
            lfsr <= SEED_EFF;
            misr <= 16'h0000;
            cnt  <= 16'h0000;
          end
          pass_q <= 1'b0;
        end
        S_RUN: begin
          lfsr <= lfsr_nx;
          misr <= misr_nx;
          cnt  <= cnt_nx;
          if (bus.abort) pass_q <= 1'b0;
        end
        S_CMP: begin
          pass_q <= bus.abort ? 1'b0 : (misr == bus.golden);
        end
        default: ;
      endcase
    end
  end

  assign bus.pat_out   = act ? lfsr : 22'h0;
  assign bus.cut_en    = (st == S_RUN);
  assign bus.busy      = act;
  assign bus.done      = (st == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = misr;
  assign bus.pat_cnt   = cnt;

endmodule

// File: tb/tb_s641_n178_bist_ctrl.sv
// Scoreboard bench for s641_n178_bist_ctrl: four instances with different PATTERNS/SEED
// share one clock and reset; each run pushes its expected result and pops it at done.
module tb_s641_n178_bist_ctrl;
  localparam logic [21:0] SEED_C = 22'h2A5F3C;
  localparam logic [21:0] MASK_C = 22'h1B3D65;

  logic CK = 1'b0;
  logic RN = 1'b0;
  always #5 CK = ~CK;

  s641_n178_bist_ctrl_if ifa();
  s641_n178_bist_ctrl_if ifb();
  s641_n178_bist_ctrl_if ifc();
  s641_n178_bist_ctrl_if ifd();

  s641_n178_bist_ctrl #(.PATTERNS(21),  .SEED(22'h000001)) ua (.CK(CK), .RN(RN), .bus(ifa));
  s641_n178_bist_ctrl #(.PATTERNS(3),   .SEED(22'h000001)) ub (.CK(CK), .RN(RN), .bus(ifb));
  s641_n178_bist_ctrl #(.PATTERNS(256), .SEED(SEED_C))     uc (.CK(CK), .RN(RN), .bus(ifc));
  s641_n178_bist_ctrl #(.PATTERNS(5),   .SEED(22'h000000)) ud (.CK(CK), .RN(RN), .bus(ifd));

  logic [3:0]        start_r = '0;
  logic [3:0]        abort_r = '0;
  logic [3:0][15:0]  golden_r = '0;
  logic [3:0][21:0]  pat_w;
  logic [3:0][15:0]  sig_w, cnt_w;
  logic [3:0]        en_w, busy_w, done_w, pass_w;

  assign ifa.start = start_r[0]; assign ifa.abort = abort_r[0]; assign ifa.golden = golden_r[0];
  assign ifb.start = start_r[1]; assign ifb.abort = abort_r[1]; assign ifb.golden = golden_r[1];
  assign ifc.start = start_r[2]; assign ifc.abort = abort_r[2]; assign ifc.golden = golden_r[2];
  assign ifd.start = start_r[3]; assign ifd.abort = abort_r[3]; assign ifd.golden = golden_r[3];
  assign ifa.cut_resp = 1'b0;
  assign ifb.cut_resp = 1'b1;
  assign ifc.cut_resp = ^(ifc.pat_out & MASK_C);
  assign ifd.cut_resp = 1'b0;

  assign pat_w  = {ifd.pat_out,   ifc.pat_out,   ifb.pat_out,   ifa.pat_out};
  assign sig_w  = {ifd.signature, ifc.signature, ifb.signature, ifa.signature};
  assign cnt_w  = {ifd.pat_cnt,   ifc.pat_cnt,   ifb.pat_cnt,   ifa.pat_cnt};
  assign en_w   = {ifd.cut_en,    ifc.cut_en,    ifb.cut_en,    ifa.cut_en};
  assign busy_w = {ifd.busy,      ifc.busy,      ifb.busy,      ifa.busy};
  assign done_w = {ifd.done,      ifc.done,      ifb.done,      ifa.done};
  assign pass_w = {ifd.pass,      ifc.pass,      ifb.pass,      ifa.pass};

  typedef struct {
    int          id;
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] lfsr_nx(input logic [21:0] q);
    return {q[20:0], q[21] ^ q[20]};
  endfunction

  function automatic logic [15:0] misr_nx(input logic [15:0] m, input logic r);
    return {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3] ^ r};
  endfunction

  // Reference signature for the parity cone driven by uc after n patterns.
  function automatic logic [15:0] cone_sig(input logic [21:0] seed, input int n);
    logic [21:0] q = seed;
    logic [15:0] m = '0;
    for (int i = 0; i < n; i++) begin
      m = misr_nx(m, ^(q & MASK_C));
      q = lfsr_nx(q);
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic push(input int id, input logic [15:0] sig, input logic p,
                      input logic [15:0] cnt, input int lat);
    exp_t e;
    e.id = id; e.sig = sig; e.pass = p; e.cnt = cnt; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic start_run(input int id);
    start_r[id] = 1'b1;
    tick();
    start_r[id] = 1'b0;
  endtask

  // lat0 = cycles already elapsed since the start edge (INIT cycle = 1).
  task automatic wait_done(input int id, input int lat0);
    int   lat = lat0;
    exp_t e;
    while (!done_w[id] && lat < 400) begin
      tick();
      lat++;
    end
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_underflow: got empty queue expected entry for dut %0d", id);
      return;
    end
    e = sb.pop_front();
    check($sformatf("id%0d", id),   id,           e.id);
    check($sformatf("lat%0d", id),  lat,          e.lat);
    check($sformatf("done%0d", id), done_w[id],   1);
    check($sformatf("busy%0d", id), busy_w[id],   0);
    check($sformatf("sig%0d", id),  sig_w[id],    e.sig);
    check($sformatf("pass%0d", id), pass_w[id],   e.pass);
    check($sformatf("cnt%0d", id),  cnt_w[id],    e.cnt);
    check($sformatf("pat%0d", id),  pat_w[id],    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] gc;
    int          lat;
    gc = cone_sig(SEED_C, 256);

    // reset state
    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_pat%0d", i),  pat_w[i],  0);
      check($sformatf("rst_busy%0d", i), busy_w[i], 0);
      check($sformatf("rst_done%0d", i), done_w[i], 0);
      check($sformatf("rst_sig%0d", i),  sig_w[i],  0);
      check($sformatf("rst_cnt%0d", i),  cnt_w[i],  0);
    end
    check("rst_en_pass", {en_w, pass_w}, 0);
    RN = 1'b1;
    tick();

    // walking LFSR, PATTERNS=21, response 0
    golden_r[0] = 16'h0000;
    push(0, 16'h0000, 1'b1, 16'd21, 24);
    start_run(0);
    check("walk_init_busy", busy_w[0], 1);
    check("walk_init_en",   en_w[0],   0);
    tick();
    check("walk_pat_first", pat_w[0], 22'h000001);
    check("walk_en_run",    en_w[0],  1);
    repeat (20) tick();
    check("walk_pat_last_run", pat_w[0], 22'h100000);
    tick();
    check("walk_pat_cmp", pat_w[0], 22'h200001);
    check("walk_en_cmp",  en_w[0],  0);
    check("walk_cnt_cmp", cnt_w[0], 21);
    wait_done(0, 23);

    // constant-one response with matching golden
    golden_r[1] = 16'h0007;
    push(1, 16'h0007, 1'b1, 16'd3, 6);
    start_run(1);
    tick(); check("one_sig_r1", sig_w[1], 16'h0000);
    tick(); check("one_sig_r2", sig_w[1], 16'h0001);
    tick(); check("one_sig_r3", sig_w[1], 16'h0003);
    tick(); check("one_sig_cmp", sig_w[1], 16'h0007);
    wait_done(1, 5);

    // mismatch, restarted from DONE
    golden_r[1] = 16'h0006;
    push(1, 16'h0007, 1'b0, 16'd3, 6);
    start_run(1);
    check("mis_init_done", done_w[1], 0);
    wait_done(1, 1);

    // asynchronous reset mid-run
    golden_r[2] = gc;
    start_run(2);
    repeat (20) tick();
    #2 RN = 1'b0;
    #1;
    check("arst_pat",  pat_w[2],  0);
    check("arst_en",   en_w[2],   0);
    check("arst_busy", busy_w[2], 0);
    check("arst_sig",  sig_w[2],  0);
    check("arst_cnt",  cnt_w[2],  0);
    check("arst_done_a", done_w[0], 0);
    check("arst_pass_a", pass_w[0], 0);
    @(negedge CK);
    RN = 1'b1;
    tick();

    // start while busy must be ignored
    push(0, 16'h0000, 1'b1, 16'd21, 24);
    start_run(0);
    for (int i = 0; i < 6; i++) begin
      start_r[0] = (i == 3);
      tick();
    end
    start_r[0] = 1'b0;
    wait_done(0, 7);

    // full run through the parity cone
    push(2, gc, 1'b1, 16'd256, 259);
    start_run(2);
    tick();
    check("cone_pat_first", pat_w[2], SEED_C);
    wait_done(2, 2);

    // abort in the 10th RUN cycle
    start_run(2);
    check("abt_init_pass", pass_w[2], 0);
    tick();
    repeat (9) tick();
    abort_r[2] = 1'b1;
    tick();
    abort_r[2] = 1'b0;
    check("abt_busy", busy_w[2], 0);
    check("abt_done", done_w[2], 0);
    check("abt_en",   en_w[2],   0);
    check("abt_pat",  pat_w[2],  0);
    check("abt_cnt",  cnt_w[2],  10);
    check("abt_sig",  sig_w[2],  cone_sig(SEED_C, 10));
    repeat (3) tick();
    check("abt_cnt_hold", cnt_w[2], 10);
    check("abt_sig_hold", sig_w[2], cone_sig(SEED_C, 10));

    // seed-zero substitution and restart from DONE
    golden_r[3] = 16'h0000;
    push(3, 16'h0000, 1'b1, 16'd5, 8);
    start_run(3);
    tick();
    check("seed0_pat", pat_w[3], 22'h000001);
    wait_done(3, 2);
    push(3, 16'h0000, 1'b1, 16'd5, 8);
    start_run(3);
    check("rst_done_cleared", done_w[3], 0);
    check("rst_pass_cleared", pass_w[3], 0);
    check("rst_busy_init",    busy_w[3], 1);
    lat = 1;
    tick(); lat++;
    check("seed0_pat2", pat_w[3], 22'h000001);
    wait_done(3, lat);

    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
